// File: rtl/siso_tx_scheduler_pkg.sv
// Shared types and defaults for the two-requester SISO transmit scheduler.
// State encoding is fixed so existing debug tooling can decode it.
package siso_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 2;

endpackage

// File: rtl/siso_tx_scheduler_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, zero latency.
// On a tie the requester that did not win last time is granted.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] & (~valid[1] | last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);

endmodule

// File: rtl/siso_tx_scheduler.sv
// Round-robin byte scheduler that serializes MSB-first onto a SISO chain; MSB appears 1 cycle after handshake.
// Requesters are only accepted in IDLE, so they stall for WIDTH+GAP_CYCLES+1 cycles per frame.
module siso_tx_scheduler
  import siso_sched_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int CNT_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             grant_id,
  output logic             busy,
  output logic             frame_done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_grant;
  logic [1:0]       grant;
  logic             hs;
  logic             last_bit;

  rr_arbiter_2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is masked by reset so nothing is accepted while the block is held.
  assign req0_ready = rst & (state == IDLE) & grant[0];
  assign req1_ready = rst & (state == IDLE) & grant[1];
  assign hs         = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign last_bit   = (state == SHIFT) && (bit_cnt == CNT_W'(WIDTH - 1));
  assign ser_out    = shreg[WIDTH-1];
  assign ser_en     = (state == SHIFT);
  assign busy       = (state != IDLE);
  assign frame_done = last_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            shreg      <= grant[1] ? req1_data : req0_data;
            bit_cnt    <= '0;
            last_grant <= grant[1];
            grant_id   <= grant[1];
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // Zero fill leaves shreg cleared after the last bit, keeping ser_out low afterwards.
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              state   <= IDLE;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_tx_scheduler.sv
// Bench for siso_tx_scheduler: directed phases plus random traffic against a frame-level queue model.
// A second instance with GAP_CYCLES=0 checks the back-to-back pattern.
module tb_siso_tx_scheduler;

  localparam int W = 8;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1;
  logic [W-1:0] d0, d1;
  logic         r0, r1, so, en, gid, bsy, done;

  logic         g_v1;
  logic [W-1:0] g_d1;
  logic         g_r0, g_r1, g_so, g_en, g_gid, g_bsy, g_done;
  logic         g_v0 = 1'b0;
  logic [W-1:0] g_d0 = '0;

  always #5 clk = ~clk;

  siso_tx_scheduler #(.WIDTH(W), .GAP_CYCLES(G)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .ser_out(so), .ser_en(en), .grant_id(gid), .busy(bsy), .frame_done(done)
  );

  siso_tx_scheduler #(.WIDTH(W), .GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .rst(rst),
    .req0_valid(g_v0), .req0_data(g_d0), .req0_ready(g_r0),
    .req1_valid(g_v1), .req1_data(g_d1), .req1_ready(g_r1),
    .ser_out(g_so), .ser_en(g_en), .grant_id(g_gid), .busy(g_bsy), .frame_done(g_done)
  );

  typedef struct {
    bit en;
    bit so;
    bit done;
  } exp_t;

  exp_t q[$];
  int   hs_cyc[$];
  int   hs_id[$];
  bit   m_last;
  bit   m_gid;
  int   cyc;
  int   checks = 0;
  int   errors = 0;
  bit   g0_on  = 1'b0;
  int   g0_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    exp_t         e;
    logic         g0, g1;
    logic [W-1:0] d;
    int           p;
    @(negedge clk);
    if (q.size() == 0) begin
      g0 = v0 && (!v1 || m_last);
      g1 = v1 && (!v0 || !m_last);
      chk("idle_ser_en", en, 0);
      chk("idle_ser_out", so, 0);
      chk("idle_frame_done", done, 0);
      chk("idle_busy", bsy, 0);
      chk("idle_ready0", r0, g0);
      chk("idle_ready1", r1, g1);
      chk("idle_grant_id", gid, m_gid);
      if (g0 || g1) begin
        m_last = g1;
        m_gid  = g1;
        d      = g1 ? d1 : d0;
        hs_cyc.push_back(cyc);
        hs_id.push_back(int'(g1));
        for (int k = W - 1; k >= 0; k--) q.push_back('{1'b1, d[k], k == 0});
        for (int k = 0; k < G; k++) q.push_back('{1'b0, 1'b0, 1'b0});
      end
    end else begin
      e = q.pop_front();
      chk("frame_ser_en", en, e.en);
      chk("frame_ser_out", so, e.so);
      chk("frame_done", done, e.done);
      chk("frame_busy", bsy, 1);
      chk("frame_ready0", r0, 0);
      chk("frame_ready1", r1, 0);
      chk("frame_grant_id", gid, m_gid);
    end
    if (g0_on) begin
      p = g0_cnt % (W + 1);
      chk("gap0_ser_en", g_en, p != 0);
      chk("gap0_ser_out", g_so, (p == 0) ? 1'b0 : g_d1[W-p]);
      chk("gap0_frame_done", g_done, p == W);
      chk("gap0_ready1", g_r1, p == 0);
      g0_cnt++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_alternation(input int min_hs);
    chk("hs_count", hs_id.size() >= min_hs, 1);
    for (int i = 1; i < hs_id.size(); i++) begin
      chk("alt_grant", hs_id[i], !hs_id[i-1]);
      chk("frame_spacing", hs_cyc[i] - hs_cyc[i-1], W + G + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'hF0; d1 = 8'h0F;
    g_v1 = 1'b0; g_d1 = '0;
    m_last = 1'b1; m_gid = 1'b0; cyc = 0;

    // Reset state, with both valids high to show ready is held low.
    #22;
    chk("rst_ser_en", en, 0);
    chk("rst_ser_out", so, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_frame_done", done, 0);
    chk("rst_ready0", r0, 0);
    chk("rst_ready1", r1, 0);
    chk("rst_grant_id", gid, 0);
    chk("rst_g0_ready1", g_r1, 0);
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Single request from req0 with 8'hB5.
    v0 = 1'b1; d0 = 8'hB5;
    cycle();
    v0 = 1'b0;
    for (int i = 0; i < 30 && q.size() != 0; i++) cycle();
    cycle();

    // Data changed during SHIFT must not corrupt the latched frame.
    v0 = 1'b1; d0 = 8'hAA;
    for (int i = 0; i < 20 && q.size() == 0; i++) cycle();
    v0 = 1'b0; d0 = 8'h55;
    for (int i = 0; i < 30 && q.size() != 0; i++) cycle();

    // Both continuously valid: strict alternation, fixed spacing.
    hs_cyc.delete(); hs_id.delete();
    v0 = 1'b1; v1 = 1'b1; d0 = 8'hF0; d1 = 8'h0F;
    for (int i = 0; i < 4 * (W + G + 1) + 2; i++) cycle();
    check_alternation(4);

    // Random traffic with data changing every cycle.
    for (int i = 0; i < 400; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      d0 = W'($urandom);
      d1 = W'($urandom);
      cycle();
    end

    // Drain, then 20 idle cycles with no requests.
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 30 && q.size() != 0; i++) cycle();
    for (int i = 0; i < 20; i++) cycle();

    // Reset asserted while the 4th bit of a frame is on the wire.
    v0 = 1'b1; d0 = 8'hC3;
    for (int i = 0; i < 20 && q.size() == 0; i++) cycle();
    v0 = 1'b0;
    for (int i = 0; i < 20 && q.size() > W + G - 3; i++) cycle();
    chk("mid_bit4_ser_en", en, 1);
    chk("mid_bit4_ser_out", so, 8'hC3 >> 4 & 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ser_en", en, 0);
    chk("mid_rst_frame_done", done, 0);
    chk("mid_rst_busy", bsy, 0);
    chk("mid_rst_ser_out", so, 0);
    q.delete(); m_last = 1'b1; m_gid = 1'b0;
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h3C; d1 = 8'h96;
    @(posedge clk); #1;
    rst = 1'b1;
    hs_cyc.delete(); hs_id.delete();
    for (int i = 0; i < 2 * (W + G + 1) + 2; i++) cycle();
    chk("post_rst_first_grant", (hs_id.size() > 0) ? hs_id[0] : -1, 0);
    check_alternation(2);

    // GAP_CYCLES=0 instance with req1 continuously valid on 8'h81.
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 30 && q.size() != 0; i++) cycle();
    g_v1 = 1'b1; g_d1 = 8'h81; g0_on = 1'b1; g0_cnt = 0;
    for (int i = 0; i < 3 * (W + 1); i++) cycle();
    g0_on = 1'b0; g_v1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
